// File: rtl/punc_mem_arbiter_pkg.sv
// Shared encodings and the tie-break helper for the PUnC memory-port arbiter.
package punc_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_RESP   = 2'd2
   } arb_state_t;

   typedef enum logic {
      ARB_OWN_CPU = 1'b0,
      ARB_OWN_DBG = 1'b1
   } arb_owner_t;

   // Round-robin pick; only meaningful when at least one request is eligible.
   function automatic arb_owner_t arb_pick(input logic i_cpu, input logic i_dbg,
                                           input arb_owner_t i_last);
      arb_owner_t w_pick;
      if (i_cpu && i_dbg) begin
         w_pick = (i_last == ARB_OWN_CPU) ? ARB_OWN_DBG : ARB_OWN_CPU;
      end else if (i_cpu) begin
         w_pick = ARB_OWN_CPU;
      end else begin
         w_pick = ARB_OWN_DBG;
      end
      return w_pick;
   endfunction

endpackage

// File: rtl/punc_mem_arbiter_sat_counter.sv
// Generic saturating up-counter with asynchronous clear; sticks at all-ones.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/punc_mem_arbiter.sv
// Arbitrates the single PUnC memory port between the CPU and the debug/loader port.
// state      | meaning
// ARB_IDLE   | arbitrate eligible requests, latch winner's fields
// ARB_ACCESS | drive memory strobe from latched fields
// ARB_RESP   | ack owner with synchronous memory read data
module punc_mem_arbiter
   import punc_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic              o_cpu_ack,
   output logic [DATA_W-1:0] o_cpu_rdata,
   input  logic              i_dbg_req,
   input  logic              i_dbg_we,
   input  logic [ADDR_W-1:0] i_dbg_addr,
   input  logic [DATA_W-1:0] i_dbg_wdata,
   output logic              o_dbg_ack,
   output logic [DATA_W-1:0] o_dbg_rdata,
   input  logic              i_dbg_freeze,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic [CNT_W-1:0]  o_stall_cnt
);

   arb_state_t        r_state, w_state_nxt;
   arb_owner_t        r_owner, r_last, w_win;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              w_cpu_elig, w_dbg_elig, w_grant;
   logic              w_cpu_ack, w_dbg_ack;

   // Freeze only gates new CPU grants; an in-flight CPU access still finishes.
   assign w_cpu_elig = i_cpu_req & ~i_dbg_freeze;
   assign w_dbg_elig = i_dbg_req;

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_win       = arb_pick(w_cpu_elig, w_dbg_elig, r_last);
      case (r_state)
         ARB_IDLE: begin
            if (w_cpu_elig || w_dbg_elig) begin
               w_grant     = 1'b1;
               w_state_nxt = ARB_ACCESS;
            end
         end
         ARB_ACCESS: w_state_nxt = ARB_RESP;
         ARB_RESP:   w_state_nxt = ARB_IDLE;
         default:    w_state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_owner <= ARB_OWN_CPU;
         r_last  <= ARB_OWN_DBG;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         if (w_grant) begin
            r_owner <= w_win;
            if (w_win == ARB_OWN_CPU) begin
               r_we    <= i_cpu_we;
               r_addr  <= i_cpu_addr;
               r_wdata <= i_cpu_wdata;
            end else begin
               r_we    <= i_dbg_we;
               r_addr  <= i_dbg_addr;
               r_wdata <= i_dbg_wdata;
            end
         end
         if (r_state == ARB_ACCESS) begin
            r_last <= r_owner;
         end
      end
   end

   // Outputs decode straight from state so an async reset clears them at once.
   always_comb begin
      o_mem_en    = (r_state == ARB_ACCESS);
      o_mem_we    = (r_state == ARB_ACCESS) && r_we;
      o_mem_addr  = r_addr;
      o_mem_wdata = r_wdata;
      w_cpu_ack   = (r_state == ARB_RESP) && (r_owner == ARB_OWN_CPU);
      w_dbg_ack   = (r_state == ARB_RESP) && (r_owner == ARB_OWN_DBG);
      o_cpu_rdata = w_cpu_ack ? i_mem_rdata : '0;
      o_dbg_rdata = w_dbg_ack ? i_mem_rdata : '0;
   end

   assign o_cpu_ack = w_cpu_ack;
   assign o_dbg_ack = w_dbg_ack;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_inc (i_cpu_req & ~w_cpu_ack),
      .o_cnt (o_stall_cnt)
   );

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run against a transaction-level model.
module tb_punc_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, cpu_ack;
   logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        dbg_req, dbg_we, dbg_ack;
   logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic        dbg_freeze;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic [15:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:65535];

   always #5 clk = ~clk;

   punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .CNT_W(16)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
      .i_cpu_wdata(cpu_wdata), .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata),
      .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr),
      .i_dbg_wdata(dbg_wdata), .o_dbg_ack(dbg_ack), .o_dbg_rdata(dbg_rdata),
      .i_dbg_freeze(dbg_freeze),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
      .o_stall_cnt(stall_cnt)
   );

   // Memory macro: synchronous read with one-cycle latency.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         mem_rdata <= mem[mem_addr];
      end
   end

   function automatic logic [15:0] init_val(input int a);
      return 16'(a * 7) ^ 16'hA5C3;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
      dbg_freeze = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1;
      sample();
      checks++;
      if ({cpu_ack, dbg_ack, mem_en, mem_we} !== 4'b0000) begin
         errors++; $display("FAIL reset_ctrl: acks/mem_en/mem_we=%b expected 0000", {cpu_ack, dbg_ack, mem_en, mem_we});
      end
      checks++;
      if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt); end
      checks++;
      if ({cpu_rdata, dbg_rdata} !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", {cpu_rdata, dbg_rdata}); end
      step();
      rst = 0;
   endtask

   task automatic test_cpu_read();
      do_reset();
      mem[16'h3000] = 16'h1234;
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
      sample();
      checks++;
      if (mem_en !== 1'b0) begin errors++; $display("FAIL rd_c0_mem_en: got %b expected 0", mem_en); end
      step(); sample();
      checks++;
      if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h3000}) begin
         errors++; $display("FAIL rd_c1_access: en=%b we=%b addr=%h expected 1 0 3000", mem_en, mem_we, mem_addr);
      end
      step(); sample();
      checks++;
      if ({cpu_ack, cpu_rdata} !== {1'b1, 16'h1234}) begin
         errors++; $display("FAIL rd_c2_ack: ack=%b rdata=%h expected 1 1234", cpu_ack, cpu_rdata);
      end
      checks++;
      if (stall_cnt !== 16'd2) begin errors++; $display("FAIL rd_stall: got %0d expected 2", stall_cnt); end
      step();
      cpu_req = 0;
      sample();
      checks++;
      if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_pulse: got %b expected 0", cpu_ack); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
      dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0010;
      step(); step(); sample();
      checks++;
      if ({cpu_ack, dbg_ack} !== 2'b10) begin errors++; $display("FAIL sim_c2_acks: cpu/dbg=%b expected 10", {cpu_ack, dbg_ack}); end
      step();
      cpu_req = 0;
      step(); sample();
      checks++;
      if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0010}) begin
         errors++; $display("FAIL sim_c4_access: en=%b we=%b addr=%h expected 1 0 0010", mem_en, mem_we, mem_addr);
      end
      step(); sample();
      checks++;
      if ({dbg_ack, dbg_rdata, cpu_ack} !== {1'b1, 16'hBEEF, 1'b0}) begin
         errors++; $display("FAIL sim_c5_dbg: ack=%b rdata=%h cpu_ack=%b expected 1 beef 0", dbg_ack, dbg_rdata, cpu_ack);
      end
      step();
      dbg_req = 0;
   endtask

   task automatic test_round_robin();
      int n_acks;
      int exp_owner;
      do_reset();
      cpu_req = 1; cpu_addr = 16'h0100;
      dbg_req = 1; dbg_addr = 16'h0200;
      n_acks = 0;
      exp_owner = 0;
      for (int c = 0; c < 30 && n_acks < 4; c++) begin
         sample();
         if (cpu_ack && dbg_ack) begin
            checks++; errors++; $display("FAIL rr_both_acked: cycle %0d", c);
         end else if (cpu_ack || dbg_ack) begin
            checks++;
            if (int'(dbg_ack) !== exp_owner) begin
               errors++; $display("FAIL rr_order: ack %0d owner=%0d expected %0d", n_acks, int'(dbg_ack), exp_owner);
            end
            exp_owner = 1 - exp_owner;
            n_acks++;
         end
         step();
      end
      checks++;
      if (n_acks != 4) begin errors++; $display("FAIL rr_count: got %0d acks expected 4", n_acks); end
      cpu_req = 0; dbg_req = 0;
   endtask

   task automatic test_freeze();
      int seen_bad;
      do_reset();
      mem[16'h3000] = 16'h1234;
      dbg_freeze = 1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
      seen_bad = 0;
      for (int i = 0; i < 10; i++) begin
         sample();
         if (cpu_ack || mem_en) seen_bad++;
         step();
      end
      checks++;
      if (seen_bad != 0) begin errors++; $display("FAIL frz_blocked: %0d cycles with ack/mem_en, expected 0", seen_bad); end
      dbg_freeze = 0;
      sample();
      checks++;
      if (stall_cnt !== 16'd10) begin errors++; $display("FAIL frz_stall: got %0d expected 10", stall_cnt); end
      step(); step(); sample();
      checks++;
      if ({cpu_ack, cpu_rdata} !== {1'b1, 16'h1234}) begin
         errors++; $display("FAIL frz_release_ack: ack=%b rdata=%h expected 1 1234", cpu_ack, cpu_rdata);
      end
      step();
      cpu_req = 0;
   endtask

   task automatic test_freeze_mid();
      do_reset();
      mem[16'h0020] = 16'h5A5A;
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
      step();
      dbg_freeze = 1;
      step(); sample();
      checks++;
      if ({cpu_ack, cpu_rdata} !== {1'b1, 16'h5A5A}) begin
         errors++; $display("FAIL frzmid_ack: ack=%b rdata=%h expected 1 5a5a", cpu_ack, cpu_rdata);
      end
      step();
      cpu_req = 0; dbg_freeze = 0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      mem[16'h3000] = 16'h1234;
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
      step(); sample();
      checks++;
      if (mem_en !== 1'b1) begin errors++; $display("FAIL rstmid_pre: mem_en=%b expected 1", mem_en); end
      #1 rst = 1;
      #1;
      checks++;
      if ({mem_en, cpu_ack, dbg_ack, stall_cnt} !== 19'd0) begin
         errors++; $display("FAIL rstmid_async: en=%b acks=%b stall=%0d expected 0", mem_en, {cpu_ack, dbg_ack}, stall_cnt);
      end
      #1 rst = 0;
      step(); sample();
      checks++;
      if ({mem_en, mem_addr} !== {1'b1, 16'h3000}) begin
         errors++; $display("FAIL rstmid_access: en=%b addr=%h expected 1 3000", mem_en, mem_addr);
      end
      step(); sample();
      checks++;
      if ({cpu_ack, cpu_rdata} !== {1'b1, 16'h1234}) begin
         errors++; $display("FAIL rstmid_ack: ack=%b rdata=%h expected 1 1234", cpu_ack, cpu_rdata);
      end
      step();
      cpu_req = 0;
   endtask

   // Randomized traffic; model: serialized accesses, each granted in the first free
   // cycle, acked two cycles later, next grant three cycles after; ties alternate.
   task automatic test_random();
      logic [15:0] mdl_mem [0:15];
      int          free_at, last_own, stall_mdl;
      int          cpu_ack_at, dbg_ack_at;
      bit          cpu_busy, dbg_busy, cpu_rd, dbg_rd, cpu_gnt, dbg_gnt;
      logic [15:0] cpu_exp, dbg_exp;
      bit          ce, de, exp_ca, exp_da;
      int          win;

      for (int i = 0; i < 16; i++) mdl_mem[i] = mem[16'h4000 + i];
      do_reset();
      free_at = 0; last_own = 1; stall_mdl = 0;
      cpu_ack_at = -1; dbg_ack_at = -1;
      cpu_busy = 0; dbg_busy = 0; cpu_gnt = 0; dbg_gnt = 0;
      cpu_rd = 0; dbg_rd = 0; cpu_exp = 0; dbg_exp = 0;

      for (int c = 0; c < 600; c++) begin
         if (c != 0) step();
         if (($urandom % 8) == 0) dbg_freeze = ~dbg_freeze;
         if (!cpu_busy && (($urandom % 3) == 0)) begin
            cpu_busy = 1; cpu_req = 1; cpu_we = $urandom % 2;
            cpu_addr = 16'h4000 | 16'($urandom_range(0, 15)); cpu_wdata = 16'($urandom);
         end else if (!cpu_busy || cpu_gnt) begin
            cpu_req = cpu_busy; cpu_we = $urandom % 2;
            cpu_addr = 16'h4000 | 16'($urandom_range(0, 15)); cpu_wdata = 16'($urandom);
         end
         if (!dbg_busy && (($urandom % 3) == 0)) begin
            dbg_busy = 1; dbg_req = 1; dbg_we = $urandom % 2;
            dbg_addr = 16'h4000 | 16'($urandom_range(0, 15)); dbg_wdata = 16'($urandom);
         end else if (!dbg_busy || dbg_gnt) begin
            dbg_req = dbg_busy; dbg_we = $urandom % 2;
            dbg_addr = 16'h4000 | 16'($urandom_range(0, 15)); dbg_wdata = 16'($urandom);
         end
         sample();

         checks++;
         if (stall_cnt !== 16'(stall_mdl)) begin
            errors++; $display("FAIL rnd_stall: cycle %0d got %0d expected %0d", c, stall_cnt, stall_mdl);
         end
         exp_ca = (c == cpu_ack_at);
         exp_da = (c == dbg_ack_at);
         checks++;
         if ({cpu_ack, dbg_ack} !== {exp_ca, exp_da}) begin
            errors++; $display("FAIL rnd_acks: cycle %0d cpu/dbg=%b expected %b", c, {cpu_ack, dbg_ack}, {exp_ca, exp_da});
         end
         if (exp_ca && cpu_rd) begin
            checks++;
            if (cpu_rdata !== cpu_exp) begin
               errors++; $display("FAIL rnd_cpu_rdata: cycle %0d got %h expected %h", c, cpu_rdata, cpu_exp);
            end
         end
         if (exp_da && dbg_rd) begin
            checks++;
            if (dbg_rdata !== dbg_exp) begin
               errors++; $display("FAIL rnd_dbg_rdata: cycle %0d got %h expected %h", c, dbg_rdata, dbg_exp);
            end
         end
         if (!exp_ca && !exp_da) begin
            checks++;
            if ({cpu_rdata, dbg_rdata} !== 32'd0) begin
               errors++; $display("FAIL rnd_idle_rdata: cycle %0d got %h expected 0", c, {cpu_rdata, dbg_rdata});
            end
         end

         if (cpu_req && !exp_ca && stall_mdl < 65535) stall_mdl++;
         if (exp_ca) begin cpu_busy = 0; cpu_gnt = 0; end
         if (exp_da) begin dbg_busy = 0; dbg_gnt = 0; end

         if (c >= free_at) begin
            ce = cpu_req && !dbg_freeze;
            de = dbg_req;
            win = -1;
            if (ce && de) win = 1 - last_own;
            else if (ce) win = 0;
            else if (de) win = 1;
            if (win == 0) begin
               cpu_ack_at = c + 2; cpu_gnt = 1; cpu_rd = !cpu_we;
               if (cpu_we) mdl_mem[cpu_addr[3:0]] = cpu_wdata;
               else cpu_exp = mdl_mem[cpu_addr[3:0]];
            end else if (win == 1) begin
               dbg_ack_at = c + 2; dbg_gnt = 1; dbg_rd = !dbg_we;
               if (dbg_we) mdl_mem[dbg_addr[3:0]] = dbg_wdata;
               else dbg_exp = mdl_mem[dbg_addr[3:0]];
            end
            if (win >= 0) begin
               free_at  = c + 3;
               last_own = win;
            end
         end
      end
      step();
      clear_inputs();
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = init_val(i);
      mem_rdata = 16'd0;
      clear_inputs();
      rst = 1;
      test_reset();
      test_cpu_read();
      test_simultaneous();
      test_round_robin();
      test_freeze();
      test_freeze_mid();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
